custom_axi_ip_regs: RTL

AXI4-Lite register front-end for the custom processing IP: software writes an operand and a start command over AXI4-Lite, and this block drives the IP's data/enable inputs. It also captures the IP's result and status outputs into readable registers. It sits between the system interconnect and the IP core, and is the register-side end of the IP's register-to-hardware interface.

---
 rtl/custom_axi_ip_regs.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/custom_axi_ip_regs.sv
// AXI4-Lite register front-end for the custom processing IP: operand/start out, result/status in.
// Optional interrupt output and CTRL.IE bit are built when CUSTOM_AXI_IP_REGS_IRQ_EN is defined.
module custom_axi_ip_regs #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr_i,
    input  logic                      s_awvalid_i,
    output logic                      s_awready_o,
    input  logic [DATA_WIDTH-1:0]     s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb_i,
    input  logic                      s_wvalid_i,
    output logic                      s_wready_o,
    output logic [1:0]                s_bresp_o,
    output logic                      s_bvalid_o,
    input  logic                      s_bready_i,
    input  logic [ADDR_WIDTH-1:0]     s_araddr_i,
    input  logic                      s_arvalid_i,
    output logic                      s_arready_o,
    output logic [DATA_WIDTH-1:0]     s_rdata_o,
    output logic [1:0]                s_rresp_o,
    output logic                      s_rvalid_o,
    input  logic                      s_rready_i,
    output logic [DATA_WIDTH-1:0]     hw_din_o,
    output logic                      hw_enable_o,
    input  logic [DATA_WIDTH:0]       hw_dout_i,
    input  logic [1:0]                hw_enable_i,
    input  logic [2:0]                hw_status_i
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
    ,
    output logic                      irq_o
`endif
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_DIN    = 2'd1,
        REG_RESULT = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  result_valid_q;
    logic                  overrun_q;
    logic                  busy_q;
    logic                  hw_enable_q;
    logic                  ie_q;

    logic                  wr_accept;
    logic                  rd_accept;
    logic                  wr_in_range;
    logic                  rd_in_range;
    reg_sel_e              wr_sel;
    reg_sel_e              rd_sel;
    logic                  capture;
    logic                  busy_eff;
    logic                  start_req;
    logic                  start_ok;
    logic                  ctrl_wr;
    logic                  din_wr;
    logic                  rd_result;
    logic [1:0]            wr_resp;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_resp;
    logic [DATA_WIDTH-1:0] status_word;
    logic [DATA_WIDTH-1:0] ctrl_word;
    logic                  unused_bits;

    assign unused_bits = ^{s_awaddr_i[1:0], s_araddr_i[1:0], hw_enable_i[1]};

    // Address and write data are accepted together, and only when no B beat is outstanding.
    assign wr_accept   = rst_ni & s_awvalid_i & s_wvalid_i & ~bvalid_q;
    assign rd_accept   = rst_ni & s_arvalid_i & ~rvalid_q;
    assign s_awready_o = wr_accept;
    assign s_wready_o  = wr_accept;
    assign s_arready_o = rd_accept;

    assign wr_in_range = ((s_awaddr_i >> 4) == '0);
    assign rd_in_range = ((s_araddr_i >> 4) == '0);
    assign wr_sel      = reg_sel_e'(s_awaddr_i[3:2]);
    assign rd_sel      = reg_sel_e'(s_araddr_i[3:2]);

    // A result arriving in the same cycle as a START frees the IP before the START is judged.
    assign capture   = hw_dout_i[0] & hw_enable_i[0];
    assign busy_eff  = busy_q & ~capture;
    assign ctrl_wr   = wr_accept & wr_in_range & (wr_sel == REG_CTRL) & s_wstrb_i[0];
    assign din_wr    = wr_accept & wr_in_range & (wr_sel == REG_DIN);
    assign start_req = ctrl_wr & s_wdata_i[0];
    assign start_ok  = start_req & ~busy_eff;
    assign rd_result = rd_accept & rd_in_range & (rd_sel == REG_RESULT);

    always_comb begin
        wr_resp = RESP_OKAY;
        if (!wr_in_range || (start_req && busy_eff)) begin
            wr_resp = RESP_SLVERR;
        end
    end

`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
    assign ctrl_word = {{(DATA_WIDTH-2){1'b0}}, ie_q, 1'b0};
`else
    assign ctrl_word = '0;
`endif

    assign status_word = {{(DATA_WIDTH-11){1'b0}}, busy_q, overrun_q, result_valid_q,
                          5'b00000, hw_status_i};

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        if (!rd_in_range) begin
            rd_resp = RESP_SLVERR;
        end else begin
            case (rd_sel)
                REG_CTRL:   rd_data = ctrl_word;
                REG_DIN:    rd_data = din_q;
                REG_RESULT: rd_data = result_q;
                REG_STATUS: rd_data = status_word;
                default:    rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (wr_accept) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_resp;
        end else if (s_bready_i) begin
            bvalid_q <= 1'b0;
        end
    end

    // Read data is captured once at accept and held until the R handshake completes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (rd_accept) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_resp;
            rdata_q  <= rd_data;
        end else if (s_rready_i) begin
            rvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            din_q <= '0;
        end else if (din_wr) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (s_wstrb_i[b]) begin
                    din_q[b*8 +: 8] <= s_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ie_q <= 1'b0;
        end else if (ctrl_wr) begin
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
            ie_q <= s_wdata_i[1];
`else
            ie_q <= 1'b0;
`endif
        end
    end

    // A RESULT read in the capture cycle consumes the old value, so it is not an overrun.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            busy_q         <= 1'b0;
            hw_enable_q    <= 1'b0;
        end else begin
            hw_enable_q <= start_ok;
            if (capture) begin
                result_q       <= hw_dout_i[DATA_WIDTH:1];
                result_valid_q <= 1'b1;
                if (result_valid_q && !rd_result) begin
                    overrun_q <= 1'b1;
                end
            end else if (rd_result) begin
                result_valid_q <= 1'b0;
            end
            if (start_ok) begin
                busy_q <= 1'b1;
            end else if (capture) begin
                busy_q <= 1'b0;
            end
        end
    end

`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= result_valid_q & ie_q;
        end
    end

    assign irq_o = irq_q;
`endif

    assign s_bvalid_o  = bvalid_q;
    assign s_bresp_o   = bresp_q;
    assign s_rvalid_o  = rvalid_q;
    assign s_rresp_o   = rresp_q;
    assign s_rdata_o   = rdata_q;
    assign hw_din_o    = din_q;
    assign hw_enable_o = hw_enable_q;

endmodule
